dbus_ram_responder: RTL and testbench

//  Responder (slave) end of the CPU D-master bus: answers dcyc/dstb requests from the

---
 rtl/dbus_ram_responder_if.sv | 24 ++
 rtl/dbus_ram_responder.sv | 226 ++++++++++++++++++++++
 tb/tb_dbus_ram_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dbus_ram_responder_if.sv
// Data-bus link between the core (master) and a RAM responder (slave).
// Signal names follow the responder's view of the bus.
interface dbus_ram_responder_if;
    logic        dcyc_i;
    logic        dstb_i;
    logic        dwe_i;
    logic [63:0] dadr_i;
    logic [1:0]  dsiz_i;
    logic        dsigned_i;
    logic [63:0] ddat_i;
    logic [63:0] ddat_o;
    logic        dack_o;
    logic        derr_o;

    modport master (
        output dcyc_i, dstb_i, dwe_i, dadr_i, dsiz_i, dsigned_i, ddat_i,
        input  ddat_o, dack_o, derr_o
    );

    modport slave (
        input  dcyc_i, dstb_i, dwe_i, dadr_i, dsiz_i, dsigned_i, ddat_i,
        output ddat_o, dack_o, derr_o
    );
endinterface

// File: rtl/dbus_ram_responder.sv
// RAM responder on the CPU data bus: 64-bit-wide internal RAM, sized
// little-endian byte-lane access, optional sign extension on reads,
// programmable wait states and a misaligned-access error flag.
module dbus_ram_responder #(
    parameter logic [63:0] BASE_ADR    = 64'h0000_0000_0000_0000,
    parameter int          DEPTH_LOG2  = 9,
    parameter int          WAIT_STATES = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    dbus_ram_responder_if.slave  bus
);

    localparam int          DEPTH     = 32'sd1 << DEPTH_LOG2;
    localparam logic [63:0] WIN_BYTES = 64'd8 << DEPTH_LOG2;
    localparam bit          HAS_WAIT  = (WAIT_STATES > 32'sd0);
    localparam logic [3:0]  CNT_INIT  = HAS_WAIT ? 4'(WAIT_STATES - 32'sd1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // Lane-offset misalignment check for the given transfer size.
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] siz);
        logic mis;
        case (siz)
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            2'b10:   mis = |off[1:0];
            2'b11:   mis = |off[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-enable mask covering lanes off .. off+size-1.
    function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] siz);
        logic [7:0] m;
        case (siz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            2'b11:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m << off;
    endfunction

    // Extract the selected lanes, right-justify, then zero- or sign-extend.
    function automatic logic [63:0] extract_lanes(input logic [63:0] word, input logic [2:0] off,
                                                  input logic [1:0] siz, input logic sgn);
        logic [63:0] sh;
        logic [63:0] res;
        sh = word >> {off, 3'b000};
        case (siz)
            2'b00:   res = sgn ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
            2'b01:   res = sgn ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            2'b10:   res = sgn ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            2'b11:   res = sh;
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [3:0]              cnt_r, cnt_nxt_s;
    logic                    capture_s, commit_s;
    logic [63:0]             rel_s;
    logic                    in_win_s, sel_s;

    logic [DEPTH_LOG2-1:0]   idx_r;
    logic [2:0]              off_r;
    logic [1:0]              siz_r;
    logic                    we_r, sgn_r;
    logic [63:0]             wdat_r;

    logic [DEPTH_LOG2-1:0]   req_idx_s;
    logic [2:0]              req_off_s;
    logic [1:0]              req_siz_s;
    logic                    req_we_s, req_sgn_s, req_mis_s;
    logic [63:0]             req_wdat_s, rd_word_s, wr_shift_s;
    logic [7:0]              be_s;

    logic [63:0]             mem_r [DEPTH];
    logic [63:0]             ddat_r;
    logic                    dack_r, derr_r;

    assign rel_s    = bus.dadr_i - BASE_ADR;
    assign in_win_s = (bus.dadr_i >= BASE_ADR) && (rel_s < WIN_BYTES);
    assign sel_s    = bus.dcyc_i && bus.dstb_i && in_win_s;

    // Next-state and wait-counter logic of the request FSM.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_s) begin
                    capture_s = 1'b1;
                    if (HAS_WAIT) begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = CNT_INIT;
                    end else begin
                        state_nxt_s = ST_ACK;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!(bus.dcyc_i && bus.dstb_i)) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_ACK: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    assign commit_s = (state_nxt_s == ST_ACK);

    // Request fields come straight from the bus when accepting from IDLE
    // with no wait states, otherwise from the captured copy.
    always_comb begin
        if (state_r == ST_IDLE) begin
            req_idx_s  = rel_s[DEPTH_LOG2+2:3];
            req_off_s  = bus.dadr_i[2:0];
            req_siz_s  = bus.dsiz_i;
            req_we_s   = bus.dwe_i;
            req_sgn_s  = bus.dsigned_i;
            req_wdat_s = bus.ddat_i;
        end else begin
            req_idx_s  = idx_r;
            req_off_s  = off_r;
            req_siz_s  = siz_r;
            req_we_s   = we_r;
            req_sgn_s  = sgn_r;
            req_wdat_s = wdat_r;
        end
    end

    assign req_mis_s  = is_misaligned(req_off_s, req_siz_s);
    assign be_s       = lane_mask(req_off_s, req_siz_s);
    assign wr_shift_s = req_wdat_s << {req_off_s, 3'b000};
    assign rd_word_s  = mem_r[req_idx_s];

    // FSM state and wait counter registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Capture the request fields when a transfer is accepted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_r  <= '0;
            off_r  <= 3'd0;
            siz_r  <= 2'd0;
            we_r   <= 1'b0;
            sgn_r  <= 1'b0;
            wdat_r <= 64'd0;
        end else if (capture_s) begin
            idx_r  <= rel_s[DEPTH_LOG2+2:3];
            off_r  <= bus.dadr_i[2:0];
            siz_r  <= bus.dsiz_i;
            we_r   <= bus.dwe_i;
            sgn_r  <= bus.dsigned_i;
            wdat_r <= bus.ddat_i;
        end
    end

    // Byte-lane RAM write on the edge entering ACK; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (commit_s && req_we_s && !req_mis_s && !reset_i) begin
            for (int b = 0; b < 8; b++) begin
                if (be_s[b]) begin
                    mem_r[req_idx_s][b*8 +: 8] <= wr_shift_s[b*8 +: 8];
                end
            end
        end
    end

    // Response registers: non-zero only during the single ACK cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dack_r <= 1'b0;
            derr_r <= 1'b0;
            ddat_r <= 64'd0;
        end else if (commit_s) begin
            dack_r <= 1'b1;
            derr_r <= req_mis_s;
            if (req_mis_s || req_we_s) begin
                ddat_r <= 64'd0;
            end else begin
                ddat_r <= extract_lanes(rd_word_s, req_off_s, req_siz_s, req_sgn_s);
            end
        end else begin
            dack_r <= 1'b0;
            derr_r <= 1'b0;
            ddat_r <= 64'd0;
        end
    end

    assign bus.dack_o = dack_r;
    assign bus.derr_o = derr_r;
    assign bus.ddat_o = ddat_r;

endmodule

// File: tb/tb_dbus_ram_responder.sv
// Directed bench for dbus_ram_responder: one instance with no wait states
// at base 0, one with three wait states at base 0x10000.
module tb_dbus_ram_responder;

    localparam logic [63:0] B3 = 64'h0000_0000_0001_0000;

    logic clk = 1'b0;
    logic rst0, rst3;
    logic tgt;
    logic r_cyc, r_stb, r_we, r_sgn;
    logic [63:0] r_adr, r_wdat;
    logic [1:0]  r_siz;
    logic        obs_ack, obs_err;
    logic [63:0] obs_dat;
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dbus_ram_responder_if b0 ();
    dbus_ram_responder_if b3 ();

    assign b0.dcyc_i = r_cyc & ~tgt;
    assign b0.dstb_i = r_stb & ~tgt;
    assign b3.dcyc_i = r_cyc & tgt;
    assign b3.dstb_i = r_stb & tgt;
    assign b0.dwe_i = r_we;      assign b3.dwe_i = r_we;
    assign b0.dadr_i = r_adr;    assign b3.dadr_i = r_adr;
    assign b0.dsiz_i = r_siz;    assign b3.dsiz_i = r_siz;
    assign b0.dsigned_i = r_sgn; assign b3.dsigned_i = r_sgn;
    assign b0.ddat_i = r_wdat;   assign b3.ddat_i = r_wdat;
    assign obs_ack = tgt ? b3.dack_o : b0.dack_o;
    assign obs_err = tgt ? b3.derr_o : b0.derr_o;
    assign obs_dat = tgt ? b3.ddat_o : b0.ddat_o;

    dbus_ram_responder #(.BASE_ADR(64'h0), .DEPTH_LOG2(9), .WAIT_STATES(0))
        u_dut0 (.clk_i(clk), .reset_i(rst0), .bus(b0));
    dbus_ram_responder #(.BASE_ADR(B3), .DEPTH_LOG2(9), .WAIT_STATES(3))
        u_dut3 (.clk_i(clk), .reset_i(rst3), .bus(b3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        r_cyc = 1'b0; r_stb = 1'b0; r_we = 1'b0; r_sgn = 1'b0;
        r_adr = 64'd0; r_siz = 2'd0; r_wdat = 64'd0;
    endtask

    task automatic drive(input logic we, input logic [63:0] adr, input logic [1:0] siz,
                         input logic sgn, input logic [63:0] wdat);
        r_cyc = 1'b1; r_stb = 1'b1; r_we = we; r_adr = adr;
        r_siz = siz; r_sgn = sgn; r_wdat = wdat;
    endtask

    // One transfer; lat is the cycle (0 = request cycle) in which dack was seen, -1 if never.
    task automatic xfer(input logic we, input logic [63:0] adr, input logic [1:0] siz,
                        input logic sgn, input logic [63:0] wdat,
                        output int lat, output logic [63:0] rdat, output logic err);
        tick();
        drive(we, adr, siz, sgn, wdat);
        lat = -1; rdat = 64'd0; err = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (obs_ack === 1'b1) begin
                lat = c; rdat = obs_dat; err = obs_err;
                break;
            end
        end
        tick();
        idle_bus();
        @(negedge clk);
        chk("ack_pulse", {63'd0, obs_ack}, 64'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [63:0] adr, input logic [1:0] siz,
                          input logic sgn, input int exp_lat, input logic [63:0] exp_dat,
                          input logic exp_err);
        int lat;
        logic [63:0] d;
        logic e;
        xfer(1'b0, adr, siz, sgn, 64'd0, lat, d, e);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_dat"}, d, exp_dat);
        chk({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    task automatic wr_chk(input string tag, input logic [63:0] adr, input logic [1:0] siz,
                          input logic [63:0] wdat, input int exp_lat, input logic exp_err);
        int lat;
        logic [63:0] d;
        logic e;
        xfer(1'b1, adr, siz, 1'b0, wdat, lat, d, e);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        idle_bus();
        tgt = 1'b0;
        rst0 = 1'b1; rst3 = 1'b1;
        tick(); tick();
        chk("rst0_ack", {63'd0, b0.dack_o}, 64'd0);
        chk("rst0_dat", b0.ddat_o, 64'd0);
        chk("rst3_ack", {63'd0, b3.dack_o}, 64'd0);
        chk("rst3_err", {63'd0, b3.derr_o}, 64'd0);
        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;

        // No wait states: dword write/read and sized reads.
        wr_chk("w_dw8", 64'd8, 2'b11, 64'h1122334455667788, 1, 1'b0);
        rd_chk("r_dw8", 64'd8, 2'b11, 1'b0, 1, 64'h1122334455667788, 1'b0);
        rd_chk("r_b8s", 64'd8, 2'b00, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FF88, 1'b0);
        rd_chk("r_b8u", 64'd8, 2'b00, 1'b0, 1, 64'h0000_0000_0000_0088, 1'b0);
        rd_chk("r_h14s", 64'd14, 2'b01, 1'b1, 1, 64'h0000_0000_0000_1122, 1'b0);
        rd_chk("r_w12s", 64'd12, 2'b10, 1'b1, 1, 64'h0000_0000_1122_3344, 1'b0);
        rd_chk("r_b13s", 64'd13, 2'b00, 1'b1, 1, 64'h0000_0000_0000_0033, 1'b0);

        // Half write into lanes 2..3 only.
        wr_chk("w_h10", 64'd10, 2'b01, 64'h0000_0000_0000_BEEF, 1, 1'b0);
        rd_chk("r_dw8b", 64'd8, 2'b11, 1'b0, 1, 64'h1122_3344_BEEF_7788, 1'b0);
        rd_chk("r_h10s", 64'd10, 2'b01, 1'b1, 1, 64'hFFFF_FFFF_FFFF_BEEF, 1'b0);
        rd_chk("r_w8u", 64'd8, 2'b10, 1'b0, 1, 64'h0000_0000_BEEF_7788, 1'b0);
        rd_chk("r_w8s", 64'd8, 2'b10, 1'b1, 1, 64'hFFFF_FFFF_BEEF_7788, 1'b0);

        // Byte write uses only the low data byte.
        wr_chk("w_b15", 64'd15, 2'b00, 64'hDEAD_BEEF_0000_00A5, 1, 1'b0);
        rd_chk("r_dw8c", 64'd8, 2'b11, 1'b0, 1, 64'hA522_3344_BEEF_7788, 1'b0);
        rd_chk("r_b15s", 64'd15, 2'b00, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0);

        // Misaligned accesses: acked with error, no data, RAM untouched.
        rd_chk("r_w10mis", 64'd10, 2'b10, 1'b0, 1, 64'd0, 1'b1);
        rd_chk("r_dw12mis", 64'd12, 2'b11, 1'b0, 1, 64'd0, 1'b1);
        wr_chk("w_h9mis", 64'd9, 2'b01, 64'h0000_0000_0000_AAAA, 1, 1'b1);
        rd_chk("r_dw8d", 64'd8, 2'b11, 1'b0, 1, 64'hA522_3344_BEEF_7788, 1'b0);

        // Window boundaries.
        wr_chk("w_last", 64'd4088, 2'b11, 64'hCAFE_F00D_0123_4567, 1, 1'b0);
        rd_chk("r_last", 64'd4088, 2'b11, 1'b0, 1, 64'hCAFE_F00D_0123_4567, 1'b0);
        rd_chk("r_oor", 64'd4096, 2'b11, 1'b0, -1, 64'd0, 1'b0);

        // Three wait states.
        tgt = 1'b1;
        wr_chk("w3_dw0", B3, 2'b11, 64'hA5A5_0000_5A5A_FFFF, 4, 1'b0);
        rd_chk("r3_dw0", B3, 2'b11, 1'b0, 4, 64'hA5A5_0000_5A5A_FFFF, 1'b0);
        rd_chk("r3_below", 64'd8, 2'b11, 1'b0, -1, 64'd0, 1'b0);

        // Strobe dropped in cycle 2 of a write: aborted, no ack, no write.
        tick(); drive(1'b1, B3, 2'b11, 1'b0, 64'h0123_4567_89AB_CDEF);
        tick();
        tick(); r_stb = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (obs_ack === 1'b1) seen = 1;
        end
        chk("abort_noack", 64'(seen), 64'd0);
        idle_bus();
        rd_chk("r3_abort", B3, 2'b11, 1'b0, 4, 64'hA5A5_0000_5A5A_FFFF, 1'b0);

        // Fields changed after acceptance are ignored.
        tick(); drive(1'b1, B3 + 64'd8, 2'b11, 1'b0, 64'h0F0E_0D0C_0B0A_0908);
        tick(); r_adr = B3 + 64'd16; r_wdat = 64'hFFFF_FFFF_FFFF_FFFF; r_we = 1'b0;
        seen = 0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (obs_ack === 1'b1 && seen == 0) seen = c;
        end
        chk("cap_lat", 64'(seen), 64'd4);
        idle_bus();
        rd_chk("r3_cap", B3 + 64'd8, 2'b11, 1'b0, 4, 64'h0F0E_0D0C_0B0A_0908, 1'b0);

        // Reset in cycle 2 of a write: dropped, next request normal.
        tick(); drive(1'b1, B3, 2'b11, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
        tick();
        tick(); rst3 = 1'b1; idle_bus();
        #1;
        chk("rstw_ack", {63'd0, b3.dack_o}, 64'd0);
        chk("rstw_dat", b3.ddat_o, 64'd0);
        #2; rst3 = 1'b0;
        tick();
        rd_chk("r3_rstw", B3, 2'b11, 1'b0, 4, 64'hA5A5_0000_5A5A_FFFF, 1'b0);

        // Reset during ACK clears outputs asynchronously.
        tick(); drive(1'b0, B3, 2'b11, 1'b0, 64'd0);
        tick(); tick(); tick(); tick();
        #1;
        chk("acka_ack", {63'd0, b3.dack_o}, 64'd1);
        chk("acka_dat", b3.ddat_o, 64'hA5A5_0000_5A5A_FFFF);
        rst3 = 1'b1; idle_bus();
        #1;
        chk("rsta_ack", {63'd0, b3.dack_o}, 64'd0);
        chk("rsta_dat", b3.ddat_o, 64'd0);
        #1; rst3 = 1'b0;
        tick();
        rd_chk("r3_rsta", B3, 2'b11, 1'b0, 4, 64'hA5A5_0000_5A5A_FFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
